// File: rtl/render_pkg.sv
// Shared types for the render command sequencer: renderer register map,
// the buffered command record and the sequencer state encoding.
package render_pkg;

  localparam logic [3:0] ADDR_X     = 4'd1;
  localparam logic [3:0] ADDR_Y     = 4'd2;
  localparam logic [3:0] ADDR_TEX   = 4'd4;
  localparam logic [3:0] ADDR_PLOT  = 4'd6;
  localparam logic [3:0] ADDR_COLOR = 4'd7;

  typedef struct packed {
    logic [6:0] texture;
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] color;
    logic       use_xy;
    logic       use_color;
  } render_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    W_TEX,
    W_X,
    W_Y,
    W_COLOR,
    W_PLOT
  } seq_state_t;

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous command FIFO. The head entry is read straight from storage
// registers; a pushed entry becomes visible at the head one cycle later.
module render_cmd_fifo
  import render_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  render_cmd_t push_data,
  input  logic        pop,
  output render_cmd_t pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  render_cmd_t   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds data only; it is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/render_cmd_sequencer.sv
// Expands buffered draw commands into renderer Avalon-MM register writes.
// Optional statistics counters are built when RENDER_SEQ_STATS_EN is defined.
module render_cmd_sequencer
  import render_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_texture,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [5:0]        cmd_color,
  input  logic              cmd_use_xy,
  input  logic              cmd_use_color,
  output logic [3:0]        master_address,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  output logic              master_read,
  input  logic              master_waitrequest,
  output logic              plot_done,
  output logic              busy,
  output logic [STAT_W-1:0] stat_plots,
  output logic [STAT_W-1:0] stat_stalls
);

  seq_state_t  state;
  seq_state_t  state_nxt;
  seq_state_t  after_xy;
  render_cmd_t cmd_in;
  render_cmd_t fifo_head;
  render_cmd_t cmd_r;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  assign cmd_in = '{texture:   cmd_texture,
                    x:         cmd_x,
                    y:         cmd_y,
                    color:     cmd_color,
                    use_xy:    cmd_use_xy,
                    use_color: cmd_use_color};

  assign cmd_ready   = !fifo_full;
  assign master_read = 1'b0;
  assign busy        = !fifo_empty || (state != IDLE);
  assign after_xy    = cmd_r.use_color ? W_COLOR : W_PLOT;

  render_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .push_data(cmd_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Command register only changes on a pop, so write data holds through stalls.
  always_ff @(posedge clk) begin
    if (fifo_pop) cmd_r <= fifo_head;
  end

  always_comb begin
    state_nxt        = state;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    fifo_pop         = 1'b0;
    plot_done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = W_TEX;
        end
      end
      W_TEX: begin
        master_write     = 1'b1;
        master_address   = ADDR_TEX;
        master_writedata = 32'(cmd_r.texture);
        if (!master_waitrequest) state_nxt = cmd_r.use_xy ? W_X : after_xy;
      end
      W_X: begin
        master_write     = 1'b1;
        master_address   = ADDR_X;
        master_writedata = 32'(cmd_r.x);
        if (!master_waitrequest) state_nxt = W_Y;
      end
      W_Y: begin
        master_write     = 1'b1;
        master_address   = ADDR_Y;
        master_writedata = 32'(cmd_r.y);
        if (!master_waitrequest) state_nxt = after_xy;
      end
      W_COLOR: begin
        master_write     = 1'b1;
        master_address   = ADDR_COLOR;
        master_writedata = 32'(cmd_r.color);
        if (!master_waitrequest) state_nxt = W_PLOT;
      end
      W_PLOT: begin
        master_write   = 1'b1;
        master_address = ADDR_PLOT;
        if (!master_waitrequest) begin
          plot_done = 1'b1;
          // Chain straight into the next command to avoid an idle bubble.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = W_TEX;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RENDER_SEQ_STATS_EN
  logic [STAT_W-1:0] plots_q;
  logic [STAT_W-1:0] stalls_q;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plots_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (plot_done)                          plots_q  <= sat_inc(plots_q);
      if (master_write && master_waitrequest) stalls_q <= sat_inc(stalls_q);
    end
  end

  assign stat_plots  = plots_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_plots  = '0;
  assign stat_stalls = '0;
`endif

endmodule
